// File: rtl/ibex_cheri_cap_access_seq.sv
// Splits one 64-bit capability load/store (plus tag) into two in-order 32-bit bus beats.
// Optional IBEX_CHERI_CAP_ALIGN_CHECK_EN: misaligned requests answer at once with misalign_o.
module ibex_cheri_cap_access_seq #(
   parameter bit          AbortOnCheriExc = 1'b1,
   parameter int unsigned CheriExcWidth   = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_i,
   output logic                     ready_o,
   input  logic                     we_i,
   input  logic [31:0]              addr_i,
   input  logic [63:0]              wdata_i,
   input  logic                     wtag_i,
   output logic                     resp_valid_o,
   output logic [63:0]              rdata_o,
   output logic                     rtag_o,
   output logic                     bus_err_o,
   output logic [CheriExcWidth-1:0] cheri_exc_o,
   output logic                     data_req_o,
   input  logic                     data_gnt_i,
   input  logic                     data_rvalid_i,
   input  logic                     data_err_i,
   input  logic [31:0]              data_rdata_i,
   input  logic                     data_rtag_i,
   output logic [31:0]              data_addr_o,
   output logic                     data_we_o,
   output logic [3:0]               data_be_o,
   output logic [31:0]              data_wdata_o,
   output logic                     data_wtag_o,
   output logic [1:0]               data_type_o,
   output logic                     data_cap_o,
   output logic                     data_first_access_o,
   input  logic [CheriExcWidth-1:0] cheri_exc_i
`ifdef IBEX_CHERI_CAP_ALIGN_CHECK_EN
   ,
   output logic                     misalign_o
`endif
);

   typedef enum logic [2:0] {
      StIdle, StLoReq, StLoWait, StHiReq, StHiWait, StResp
   } state_e;

   state_e                   state_q, state_d;
   logic                     we_q, we_d;
   logic [28:0]              base_q, base_d;
   logic [63:0]              wdata_q, wdata_d;
   logic                     wtag_q, wtag_d;
   logic [63:0]              rdata_q, rdata_d;
   logic                     tag_q, tag_d;
   logic                     bus_err_q, bus_err_d;
   logic [CheriExcWidth-1:0] exc_q, exc_d;
   logic                     misalign_q, misalign_d;
   logic                     misaligned;
   logic                     lo_beat, hi_beat;

`ifdef IBEX_CHERI_CAP_ALIGN_CHECK_EN
   assign misaligned = |addr_i[2:0];
   assign misalign_o = misalign_q & (state_q == StResp);
`else
   logic unused_sig;
   assign misaligned = 1'b0;
   assign unused_sig = misalign_q ^ (^addr_i[2:0]);
`endif

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      base_d     = base_q;
      wdata_d    = wdata_q;
      wtag_d     = wtag_q;
      rdata_d    = rdata_q;
      tag_d      = tag_q;
      bus_err_d  = bus_err_q;
      exc_d      = exc_q;
      misalign_d = misalign_q;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               we_d       = we_i;
               base_d     = addr_i[31:3];
               wdata_d    = wdata_i;
               wtag_d     = wtag_i;
               tag_d      = 1'b0;
               bus_err_d  = 1'b0;
               exc_d      = '0;
               misalign_d = misaligned;
               state_d    = misaligned ? StResp : StLoReq;
            end
         end
         StLoReq: begin
            if (data_gnt_i) state_d = StLoWait;
         end
         StLoWait: begin
            if (data_rvalid_i) begin
               rdata_d[31:0] = data_rdata_i;
               tag_d         = data_rtag_i;
               bus_err_d     = bus_err_q | data_err_i;
               // Checker registered this at the low grant; it decides whether the high beat runs.
               exc_d         = cheri_exc_i;
               if ((AbortOnCheriExc && (|cheri_exc_i)) || data_err_i) begin
                  state_d = StResp;
               end else begin
                  state_d = StHiReq;
               end
            end
         end
         StHiReq: begin
            if (data_gnt_i) state_d = StHiWait;
         end
         StHiWait: begin
            if (data_rvalid_i) begin
               rdata_d[63:32] = data_rdata_i;
               tag_d          = tag_q & data_rtag_i;
               bus_err_d      = bus_err_q | data_err_i;
               state_d        = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         base_q     <= '0;
         wdata_q    <= '0;
         wtag_q     <= 1'b0;
         rdata_q    <= '0;
         tag_q      <= 1'b0;
         bus_err_q  <= 1'b0;
         exc_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         wtag_q     <= wtag_d;
         rdata_q    <= rdata_d;
         tag_q      <= tag_d;
         bus_err_q  <= bus_err_d;
         exc_q      <= exc_d;
         misalign_q <= misalign_d;
      end
   end

   assign lo_beat = (state_q == StLoReq);
   assign hi_beat = (state_q == StHiReq);

   assign ready_o             = (state_q == StIdle);
   assign resp_valid_o        = (state_q == StResp);
   assign data_req_o          = lo_beat | hi_beat;
   assign data_addr_o         = data_req_o ? {base_q, hi_beat, 2'b00} : 32'h0;
   assign data_wdata_o        = lo_beat ? wdata_q[31:0] : (hi_beat ? wdata_q[63:32] : 32'h0);
   assign data_we_o           = data_req_o & we_q;
   assign data_wtag_o         = data_req_o & wtag_q;
   assign data_first_access_o = lo_beat;
   assign data_be_o           = 4'hF;
   assign data_type_o         = 2'b11;
   assign data_cap_o          = 1'b1;

   assign rdata_o     = rdata_q;
   // A tag is only meaningful for a clean load.
   assign rtag_o      = tag_q & ~we_q & ~bus_err_q & ~(|exc_q);
   assign bus_err_o   = bus_err_q;
   assign cheri_exc_o = exc_q;

endmodule

// File: tb/tb_ibex_cheri_cap_access_seq.sv
// Bench for ibex_cheri_cap_access_seq: instance 0 aborts on checker exceptions, instance 1 does not.
module tb_ibex_cheri_cap_access_seq;

   localparam int EW     = 8;
   localparam int LenBit = 1;
   localparam logic [EW-1:0] LenExc = EW'(1) << LenBit;

   typedef struct {
      int            s;
      logic          we;
      logic [31:0]   addr;
      logic [63:0]   wdata;
      logic          wtag;
      int            req_cycles;
      int            rv_dly;
      logic [31:0]   lo_rd;
      logic [31:0]   hi_rd;
      logic          lo_tag;
      logic          hi_tag;
      logic          lo_err;
      logic          hi_err;
      logic [EW-1:0] exc;
   } vec_t;

   typedef struct {
      logic [63:0]   rdata;
      logic          rtag;
      logic          err;
      logic [EW-1:0] exc;
      int            lat;
      int            beats;
   } exp_t;

   typedef struct {
      vec_t v;
      exp_t e;
   } row_t;

   logic          clk;
   logic          rst;
   logic          req        [2];
   logic          ready      [2];
   logic          we         [2];
   logic [31:0]   addr       [2];
   logic [63:0]   wdata      [2];
   logic          wtag       [2];
   logic          resp_valid [2];
   logic [63:0]   rdata      [2];
   logic          rtag       [2];
   logic          bus_err    [2];
   logic [EW-1:0] cexc_o     [2];
   logic          dreq       [2];
   logic          dgnt       [2];
   logic          drvalid    [2];
   logic          derr       [2];
   logic [31:0]   drdata     [2];
   logic          drtag      [2];
   logic [31:0]   daddr      [2];
   logic          dwe        [2];
   logic [3:0]    dbe        [2];
   logic [31:0]   dwdata     [2];
   logic          dwtag      [2];
   logic [1:0]    dtype      [2];
   logic          dcap       [2];
   logic          dfirst     [2];
   logic [EW-1:0] cexc_i     [2];

   int          n_chk;
   int          n_fail;
   logic [63:0] model_rdata [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ibex_cheri_cap_access_seq #(
         .AbortOnCheriExc(g == 0),
         .CheriExcWidth  (EW)
      ) dut (
         .clk_i              (clk),
         .rst_i              (rst),
         .req_i              (req[g]),
         .ready_o            (ready[g]),
         .we_i               (we[g]),
         .addr_i             (addr[g]),
         .wdata_i            (wdata[g]),
         .wtag_i             (wtag[g]),
         .resp_valid_o       (resp_valid[g]),
         .rdata_o            (rdata[g]),
         .rtag_o             (rtag[g]),
         .bus_err_o          (bus_err[g]),
         .cheri_exc_o        (cexc_o[g]),
         .data_req_o         (dreq[g]),
         .data_gnt_i         (dgnt[g]),
         .data_rvalid_i      (drvalid[g]),
         .data_err_i         (derr[g]),
         .data_rdata_i       (drdata[g]),
         .data_rtag_i        (drtag[g]),
         .data_addr_o        (daddr[g]),
         .data_we_o          (dwe[g]),
         .data_be_o          (dbe[g]),
         .data_wdata_o       (dwdata[g]),
         .data_wtag_o        (dwtag[g]),
         .data_type_o        (dtype[g]),
         .data_cap_o         (dcap[g]),
         .data_first_access_o(dfirst[g]),
         .cheri_exc_i        (cexc_i[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
      n_chk++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %h, wanted %h", nm, act, req_v);
      end
   endtask

   function automatic vec_t mkvec(input int s, input logic w, input logic [31:0] a,
                                  input logic [63:0] wd, input logic wt, input int rc,
                                  input int rv, input logic [31:0] lr, input logic [31:0] hr,
                                  input logic lt, input logic ht, input logic le,
                                  input logic he, input logic [EW-1:0] ex);
      vec_t v;
      v.s = s; v.we = w; v.addr = a; v.wdata = wd; v.wtag = wt; v.req_cycles = rc;
      v.rv_dly = rv; v.lo_rd = lr; v.hi_rd = hr; v.lo_tag = lt; v.hi_tag = ht;
      v.lo_err = le; v.hi_err = he; v.exc = ex;
      return v;
   endfunction

   function automatic exp_t mkexp(input logic [63:0] rd, input logic rt, input logic er,
                                  input logic [EW-1:0] ex, input int lat, input int beats);
      exp_t e;
      e.rdata = rd; e.rtag = rt; e.err = er; e.exc = ex; e.lat = lat; e.beats = beats;
      return e;
   endfunction

   // Reference: what one access should produce, given the bus behaviour it sees.
   function automatic exp_t model(input vec_t v, input logic [63:0] prev, input bit abort_en);
      exp_t e;
      bit   stop_early;
      stop_early = v.lo_err || (abort_en && (v.exc != '0));
      e.beats = stop_early ? 1 : 2;
      e.rdata = {stop_early ? prev[63:32] : v.hi_rd, v.lo_rd};
      e.err   = v.lo_err | (!stop_early & v.hi_err);
      e.exc   = v.exc;
      e.rtag  = !v.we && !e.err && (v.exc == '0) && v.lo_tag && v.hi_tag;
      e.lat   = 1 + e.beats * (v.req_cycles + 1 + v.rv_dly);
      return e;
   endfunction

   task automatic do_access(input vec_t v, output logic [63:0] o_rd, output logic o_rt,
                            output logic o_er, output logic [EW-1:0] o_ex, output int o_lat,
                            output int o_beats);
      int          s;
      int          cyc;
      int          held;
      int          rv_wait;
      bit          pend;
      bit          done;
      bit          exc_on;
      logic [31:0] base;
      s = v.s;
      base = {v.addr[31:3], 3'b000};
      o_rd = '0; o_rt = 1'b0; o_er = 1'b0; o_ex = '0; o_lat = 0; o_beats = 0;
      cyc = 0; held = 0; rv_wait = 0; pend = 0; done = 0; exc_on = 0;
      chk("ready_before_req", 64'(ready[s]), 64'(1));
      req[s] = 1'b1; we[s] = v.we; addr[s] = v.addr; wdata[s] = v.wdata; wtag[s] = v.wtag;
      while (!done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         req[s] = 1'b0; dgnt[s] = 1'b0; drvalid[s] = 1'b0; derr[s] = 1'b0;
         drdata[s] = '0; drtag[s] = 1'b0;
         if (exc_on) cexc_i[s] = v.exc;
         if (resp_valid[s]) begin
            o_rd = rdata[s]; o_rt = rtag[s]; o_er = bus_err[s]; o_ex = cexc_o[s];
            o_lat = cyc;
            done = 1;
         end else begin
            chk("ready_busy", 64'(ready[s]), 64'(0));
            if (dreq[s]) begin
               if (held == 0) o_beats++;
               held++;
               chk("beat_addr", 64'(daddr[s]), 64'(base + ((o_beats == 2) ? 32'd4 : 32'd0)));
               chk("beat_first", 64'(dfirst[s]), 64'(o_beats == 1));
               chk("beat_we", 64'(dwe[s]), 64'(v.we));
               chk("beat_wtag", 64'(dwtag[s]), 64'(v.wtag));
               chk("beat_wdata", 64'(dwdata[s]),
                   64'((o_beats == 2) ? v.wdata[63:32] : v.wdata[31:0]));
               if (held >= v.req_cycles) begin
                  dgnt[s] = 1'b1;
                  held = 0;
                  pend = 1;
                  rv_wait = v.rv_dly;
                  if (o_beats == 1) exc_on = 1;
               end
            end else begin
               chk("idle_bus_fields", 64'({daddr[s], dwdata[s]}), 64'(0));
               chk("idle_bus_flags", 64'({dwe[s], dwtag[s], dfirst[s]}), 64'(0));
               if (pend) begin
                  if (rv_wait == 0) begin
                     drvalid[s] = 1'b1;
                     drdata[s]  = (o_beats == 2) ? v.hi_rd : v.lo_rd;
                     drtag[s]   = (o_beats == 2) ? v.hi_tag : v.lo_tag;
                     derr[s]    = (o_beats == 2) ? v.hi_err : v.lo_err;
                     pend = 0;
                  end else begin
                     rv_wait--;
                  end
               end
            end
         end
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL resp_timeout: no resp_valid_o after %0d cycles, wanted one", cyc);
      end
      cexc_i[s] = '0;
      @(posedge clk);
      #1;
      chk("resp_one_cycle", 64'(resp_valid[s]), 64'(0));
      chk("ready_after_resp", 64'(ready[s]), 64'(1));
      chk("rdata_hold", rdata[s], o_rd);
      chk("rtag_hold", 64'(rtag[s]), 64'(o_rt));
      chk("exc_hold", 64'(cexc_o[s]), 64'(o_ex));
   endtask

   task automatic run_and_check(input string nm, input vec_t v, input exp_t e);
      logic [63:0]   rd;
      logic          rt;
      logic          er;
      logic [EW-1:0] ex;
      int            lat;
      int            beats;
      do_access(v, rd, rt, er, ex, lat, beats);
      chk({nm, "_rdata"}, rd, e.rdata);
      chk({nm, "_rtag"}, 64'(rt), 64'(e.rtag));
      chk({nm, "_bus_err"}, 64'(er), 64'(e.err));
      chk({nm, "_cheri_exc"}, 64'(ex), 64'(e.exc));
      chk({nm, "_latency"}, 64'(lat), 64'(e.lat));
      chk({nm, "_beats"}, 64'(beats), 64'(e.beats));
   endtask

   row_t tbl[8];

   initial begin
      vec_t v;
      exp_t e;
      n_chk = 0;
      n_fail = 0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0; wtag[i] = 0;
         dgnt[i] = 0; drvalid[i] = 0; derr[i] = 0; drdata[i] = '0; drtag[i] = 0;
         cexc_i[i] = '0;
         model_rdata[i] = '0;
      end

      tbl[0].v = mkvec(0, 0, 32'h1000, 64'h0, 0, 1, 0, 32'h11111111, 32'h22222222, 1, 1, 0, 0,
                       '0);
      tbl[0].e = mkexp(64'h22222222_11111111, 1, 0, '0, 5, 2);
      tbl[1].v = mkvec(0, 1, 32'h2008, 64'hAABBCCDD_00112233, 1, 3, 0, 32'h0, 32'h0, 1, 1, 0,
                       0, '0);
      tbl[1].e = mkexp(64'h0, 0, 0, '0, 9, 2);
      tbl[2].v = mkvec(0, 0, 32'h3000, 64'h0, 0, 1, 0, 32'h33333333, 32'h44444444, 1, 1, 0, 0,
                       LenExc);
      tbl[2].e = mkexp(64'h00000000_33333333, 0, 0, LenExc, 3, 1);
      tbl[3].v = mkvec(1, 0, 32'h3000, 64'h0, 0, 1, 0, 32'h33333333, 32'h44444444, 1, 1, 0, 0,
                       LenExc);
      tbl[3].e = mkexp(64'h44444444_33333333, 0, 0, LenExc, 5, 2);
      tbl[4].v = mkvec(0, 0, 32'h4000, 64'h0, 0, 1, 0, 32'h55555555, 32'h66666666, 1, 1, 1, 0,
                       '0);
      tbl[4].e = mkexp(64'h00000000_55555555, 0, 1, '0, 3, 1);
      tbl[5].v = mkvec(0, 0, 32'h5005, 64'h0, 0, 2, 2, 32'h77777777, 32'h88888888, 1, 1, 0, 1,
                       '0);
      tbl[5].e = mkexp(64'h88888888_77777777, 0, 1, '0, 11, 2);
      tbl[6].v = mkvec(1, 1, 32'h7FF8, 64'h01020304_05060708, 0, 1, 1, 32'h12345678,
                       32'h9ABCDEF0, 0, 1, 0, 0, '0);
      tbl[6].e = mkexp(64'h9ABCDEF0_12345678, 0, 0, '0, 7, 2);
      tbl[7].v = mkvec(0, 0, 32'h8000, 64'h0, 0, 1, 0, 32'hCAFEF00D, 32'h0BADBEEF, 1, 0, 0, 0,
                       '0);
      tbl[7].e = mkexp(64'h0BADBEEF_CAFEF00D, 0, 0, '0, 5, 2);

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ready", 64'(ready[i]), 64'(1));
         chk("rst_resp_valid", 64'(resp_valid[i]), 64'(0));
         chk("rst_data_req", 64'(dreq[i]), 64'(0));
         chk("rst_rdata", rdata[i], 64'(0));
         chk("rst_flags", 64'({rtag[i], bus_err[i], cexc_o[i]}), 64'(0));
         chk("const_fields", 64'({dbe[i], dtype[i], dcap[i]}), 64'({4'hF, 2'b11, 1'b1}));
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_and_check($sformatf("row%0d", i), tbl[i].v, tbl[i].e);
         model_rdata[tbl[i].v.s] = tbl[i].e.rdata;
      end

      // Reset while the high beat is outstanding, then a late response that must be dropped.
      req[0] = 1; we[0] = 0; addr[0] = 32'h6000;
      @(posedge clk);
      #1;
      req[0] = 0;
      chk("rst_seq_lo_req", 64'(dreq[0]), 64'(1));
      dgnt[0] = 1;
      @(posedge clk);
      #1;
      dgnt[0] = 0; drvalid[0] = 1; drdata[0] = 32'h99999999; drtag[0] = 1;
      @(posedge clk);
      #1;
      drvalid[0] = 0; drdata[0] = '0; drtag[0] = 0;
      chk("rst_seq_hi_addr", 64'(daddr[0]), 64'(32'h6004));
      dgnt[0] = 1;
      @(posedge clk);
      #1;
      dgnt[0] = 0;
      chk("rst_seq_lo_rdata", 64'(rdata[0][31:0]), 64'(32'h99999999));
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      drvalid[0] = 1; derr[0] = 1; drdata[0] = 32'hDEADBEEF; drtag[0] = 1;
      @(posedge clk);
      #1;
      drvalid[0] = 0; derr[0] = 0; drdata[0] = '0; drtag[0] = 0;
      for (int k = 0; k < 3; k++) begin
         chk("rst_seq_ready", 64'(ready[0]), 64'(1));
         chk("rst_seq_no_resp", 64'(resp_valid[0]), 64'(0));
         chk("rst_seq_rdata", rdata[0], 64'(0));
         chk("rst_seq_err", 64'(bus_err[0]), 64'(0));
         @(posedge clk);
         #1;
      end
      model_rdata[0] = '0;
      model_rdata[1] = '0;
      v = mkvec(0, 0, 32'h9000, 64'h0, 0, 1, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 1, 0, 0, '0);
      e = model(v, model_rdata[0], 1'b1);
      run_and_check("post_rst", v, e);
      model_rdata[0] = e.rdata;

      for (int i = 0; i < 40; i++) begin
         v.s          = int'($urandom_range(0, 1));
         v.we         = 1'($urandom_range(0, 1));
         v.addr       = $urandom();
         v.wdata      = {$urandom(), $urandom()};
         v.wtag       = 1'($urandom_range(0, 1));
         v.req_cycles = int'($urandom_range(1, 3));
         v.rv_dly     = int'($urandom_range(0, 2));
         v.lo_rd      = $urandom();
         v.hi_rd      = $urandom();
         v.lo_tag     = 1'($urandom_range(0, 3) != 0);
         v.hi_tag     = 1'($urandom_range(0, 3) != 0);
         v.lo_err     = 1'($urandom_range(0, 7) == 0);
         v.hi_err     = 1'($urandom_range(0, 7) == 0);
         v.exc        = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(1, 255)) : '0;
         e = model(v, model_rdata[v.s], v.s == 0);
         run_and_check($sformatf("rand%0d", i), v, e);
         model_rdata[v.s] = e.rdata;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ibex_cheri_cap_access_seq.md
Name: ibex_cheri_cap_access_seq

Overview:
- Sequences one 64-bit capability load or store (plus tag) from the load/store unit as two in-order 32-bit bus beats: low word, then high word.
- Drives the per-beat request fields consumed by the CHERI memory checker, including data_type = double and first-access marking.
- Consumes the checker's registered exception vector and suppresses the second beat when the first is disallowed.
- Returns a single assembled response to the requester.

Parameters:
- AbortOnCheriExc, 1'b1: 1 = skip the high beat when the checker flags the low beat; 0 = always issue both beats.
- CheriExcWidth, ibex_pkg::CheriExcWidth: width of the checker exception vector.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- req_i  in  1  capability access request; accepted only when ready_o=1
- ready_o  out  1  sequencer idle, can accept req_i
- we_i  in  1  1 = store, 0 = load
- addr_i  in  32  byte address of the capability
- wdata_i  in  64  store data
- wtag_i  in  1  store tag
- resp_valid_o  out  1  one-cycle response pulse
- rdata_o  out  64  load data, {high, low}
- rtag_o  out  1  loaded tag
- bus_err_o  out  1  bus error on any issued beat
- cheri_exc_o  out  CheriExcWidth  checker exception vector captured for this access
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus response error
- data_rdata_i  in  32  bus read data
- data_rtag_i  in  1  bus read tag
- data_addr_o  out  32  beat address
- data_we_o  out  1  beat write enable
- data_be_o  out  4  byte enables; always 4'hF
- data_wdata_o  out  32  beat write data
- data_wtag_o  out  1  beat write tag
- data_type_o  out  2  constant 2'b11 (double)
- data_cap_o  out  1  constant 1
- data_first_access_o  out  1  1 during the low beat
- cheri_exc_i  in  CheriExcWidth  checker output (stable-out mode)

Behaviour:
- States: IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, RESP.
- Reset (rst_i at a clock edge, in any state): state=IDLE; all outputs 0 except ready_o=1. In-flight beats are abandoned; responses arriving after reset are ignored.
- IDLE: ready_o=1. On req_i, latch we_i, addr_i[31:3] (bits [2:0] forced to 0), wdata_i, wtag_i, clear the error accumulators, go to LO_REQ. ready_o is 0 in every other state.
- LO_REQ: data_req_o=1, data_addr_o={addr[31:3],3'b000}, data_wdata_o=wdata[31:0], data_first_access_o=1, data_we_o=we. Fields hold stable until data_gnt_i. On grant, go to LO_WAIT.
- LO_WAIT: data_req_o=0. On data_rvalid_i:
  - capture data_rdata_i into rdata_o[31:0] and data_rtag_i into the tag accumulator;
  - OR data_err_i into bus_err;
  - capture cheri_exc_i (the checker registered it at the low grant);
  - if AbortOnCheriExc and |cheri_exc_i, or data_err_i, go to RESP; else go to HI_REQ.
- HI_REQ: address = base+4, data_wdata_o=wdata[63:32], data_first_access_o=0, data_we_o=we. On grant, go to HI_WAIT.
- HI_WAIT: on data_rvalid_i, capture rdata_o[63:32], AND data_rtag_i into the tag, OR data_err_i into bus_err, go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE.
- rtag_o = low tag & high tag; forced 0 if any error or exception, or if we=1.
- rdata_o and rtag_o hold their values after RESP until the next accepted request.
- data_wtag_o = wtag in both beats. Data/tag outputs are 0 when data_req_o=0.
- data_rvalid_i outside a *_WAIT state is ignored. Grant and rvalid in the same cycle cannot occur for the same beat; at most one beat is outstanding.
- Latency with zero-wait grants and next-cycle rvalid: accept at cycle 0; resp_valid_o at cycle 5.

Optional Feature:
- Macro: IBEX_CHERI_CAP_ALIGN_CHECK_EN.
- Defined: a request with addr_i[2:0]!=0 issues no bus beat. It goes IDLE->RESP with bus_err_o=0, cheri_exc_o=0 and misalign_o=1.
- The macro also adds port misalign_o (out, 1), valid with resp_valid_o and 0 otherwise.
- Undefined: the port is absent and addr_i[2:0] is silently ignored.

Test Plan:
- Load at 0x1000, zero-wait bus, rdata 0x11111111 then 0x22222222, both tags 1 -> beats at 0x1000 (first=1) then 0x1004 (first=0); rdata_o=0x2222222211111111, rtag_o=1, resp at cycle 5.
- Store of 0xAABBCCDD_00112233 at 0x2008 with 3-cycle grant delay -> data_req_o held 3 cycles per beat; wdata 0x00112233 then 0xAABBCCDD; resp pulse; rtag_o=0.
- cheri_exc_i=LENGTH_VIOLATION set after the low grant, AbortOnCheriExc=1 -> no beat at 0x...4; cheri_exc_o shows the length bit; rtag_o=0.
- Same as above with AbortOnCheriExc=0 -> both beats issued; exception still reported.
- data_err_i on the low beat -> no high beat; bus_err_o=1; rtag_o=0.
- rst_i asserted in HI_WAIT, then a stray data_rvalid_i -> ready_o=1, no resp_valid_o; a new load completes normally.
